// File: rtl/adder_pkg.sv
// Shared types and helpers for the chunked add/subtract unit.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Chunk-index width: clog2(WIDTH/CHUNK), never below one bit.
    function automatic int idx_width(input int width, input int chunk);
        int n;
        n = width / chunk;
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/chunk_add.sv
// One CHUNK-bit slice of the ripple adder, plus the carry into its MSB
// so the top can derive signed overflow on the final slice.
module chunk_add #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    logic [CHUNK:0] total;

    assign total    = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    assign s        = total[CHUNK-1:0];
    assign cout     = total[CHUNK];
    // The MSB sum bit is a^b^carry_in, so the carry into it falls out by XOR.
    assign c_msb_in = a[CHUNK-1] ^ b[CHUNK-1] ^ s[CHUNK-1];

endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle add/subtract: CHUNK bits per clock, LSB chunk first.
// Optional macro ADDER_ZERO_FLAG_EN adds a registered zero-result output.
module chunked_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
`ifdef ADDER_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = idx_width(WIDTH, CHUNK);

    state_t            state_reg;
    logic [IDXW-1:0]   idx_reg;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic              carry_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              cout_reg;
    logic              overflow_reg;

    logic              accept;
    logic              last_chunk;
    logic [CHUNK-1:0]  chunk_s;
    logic              chunk_cout;
    logic              chunk_c_msb;

    assign accept     = start && ((state_reg == IDLE) || (state_reg == DONE));
    assign last_chunk = (idx_reg == IDXW'(N - 1));

    // Operand registers shift right each RUN cycle, so the current chunk
    // always sits in the low bits and no wide index mux is needed.
    chunk_add #(
        .CHUNK (CHUNK)
    ) u_chunk_add (
        .a        (a_reg[CHUNK-1:0]),
        .b        (b_reg[CHUNK-1:0]),
        .cin      (carry_reg),
        .s        (chunk_s),
        .cout     (chunk_cout),
        .c_msb_in (chunk_c_msb)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg    <= IDLE;
            idx_reg      <= '0;
            carry_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            cout_reg     <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        a_reg     <= a;
                        b_reg     <= sub ? ~b : b;
                        carry_reg <= sub ? 1'b1 : cin;
                        idx_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= RUN;
                    end else begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                RUN: begin
                    a_reg     <= a_reg >> CHUNK;
                    b_reg     <= b_reg >> CHUNK;
                    carry_reg <= chunk_cout;
                    if (last_chunk) begin
                        cout_reg     <= chunk_cout;
                        overflow_reg <= chunk_cout ^ chunk_c_msb;
                        busy_reg     <= 1'b0;
                        done_reg     <= 1'b1;
                        state_reg    <= DONE;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

`ifdef ADDER_ZERO_FLAG_EN
    logic [WIDTH-1:0] sum_final;
    logic             zero_reg;
`endif

    // Each result chunk owns its register; it loads only when idx selects it.
    for (genvar gi = 0; gi < N; gi++) begin : gen_sum
        logic [CHUNK-1:0] chunk_reg;

        always_ff @(posedge clock) begin
            if (!reset) begin
                chunk_reg <= '0;
            end else if (accept) begin
                chunk_reg <= '0;
            end else if ((state_reg == RUN) && (idx_reg == IDXW'(gi))) begin
                chunk_reg <= chunk_s;
            end
        end

        assign sum[gi*CHUNK +: CHUNK] = chunk_reg;
`ifdef ADDER_ZERO_FLAG_EN
        // The top chunk is still in flight on the final edge, so use the adder output.
        assign sum_final[gi*CHUNK +: CHUNK] = (gi == N - 1) ? chunk_s : chunk_reg;
`endif
    end

`ifdef ADDER_ZERO_FLAG_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            zero_reg <= 1'b0;
        end else if ((state_reg == RUN) && last_chunk) begin
            zero_reg <= (sum_final == '0);
        end
    end

    assign zero = zero_reg;
`endif

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign cout     = cout_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_chunked_adder.sv
// Directed-vector bench for chunked_adder at WIDTH=32, CHUNK=8.
module tb_chunked_adder;

    localparam int WIDTH = 32;
    localparam int CHUNK = 8;
    localparam int N     = WIDTH / CHUNK;

    logic             clock;
    logic             reset;
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
`ifdef ADDER_ZERO_FLAG_EN
    logic             zero;
`endif

    int n_compared   = 0;
    int n_mismatched = 0;

    chunked_adder #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
`ifdef ADDER_ZERO_FLAG_EN
        ,
        .zero     (zero)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Issue one operation, then check latency, busy span, results and the one-cycle done.
    task automatic run_op(input string tag, input logic op_sub, input logic [31:0] op_a,
                          input logic [31:0] op_b, input logic op_cin,
                          input logic [31:0] exp_sum, input logic exp_cout,
                          input logic exp_ovf, input logic exp_zero);
        int lat;
        int busy_cnt;
        start = 1'b1; sub = op_sub; a = op_a; b = op_b; cin = op_cin;
        step();
        start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        lat = 0;
        busy_cnt = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cnt++;
            step();
            lat++;
        end
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " latency"}, lat, N);
        check({tag, " busy_cycles"}, busy_cnt, N);
        check({tag, " sum"}, sum, exp_sum);
        check({tag, " cout"}, 32'(cout), 32'(exp_cout));
        check({tag, " overflow"}, 32'(overflow), 32'(exp_ovf));
`ifdef ADDER_ZERO_FLAG_EN
        check({tag, " zero"}, 32'(zero), 32'(exp_zero));
`else
        if (exp_zero) begin end
`endif
        $display("op %s: sub=%0d a=0x%08h b=0x%08h -> sum=0x%08h cout=%0d ovf=%0d lat=%0d",
                 tag, op_sub, op_a, op_b, sum, cout, overflow, lat);
        step();
        check({tag, " done_one_cycle"}, 32'(done), 32'd0);
        check({tag, " sum_held"}, sum, exp_sum);
    endtask

    initial begin
        int pulses;
        reset = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
        step();
        step();
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset sum", sum, 32'd0);
        check("reset cout", 32'(cout), 32'd0);
        check("reset overflow", 32'(overflow), 32'd0);
        reset = 1'b1;
        step();

        run_op("add_1_1", 1'b0, 32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
        run_op("add_ripple", 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        run_op("add_ovf", 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        run_op("add_cin", 1'b0, 32'h0000_00FF, 32'h0000_0000, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0);

        // start pulses during RUN must be ignored; then a back-to-back start from DONE.
        start = 1'b1; sub = 1'b0; a = 32'h10; b = 32'h20; cin = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            start = 1'b1; a = 32'hDEAD_0000 + 32'(i); b = 32'h0BAD_F00D; sub = i[0];
            check("ignore busy", 32'(busy), 32'd1);
            step();
        end
        start = 1'b0;
        check("ignore not_done_yet", 32'(done), 32'd0);
        step();
        check("ignore done", 32'(done), 32'd1);
        check("ignore sum", sum, 32'h30);
        start = 1'b1; sub = 1'b0; a = 32'd3; b = 32'd4; cin = 1'b0;
        step();
        start = 1'b0;
        check("b2b busy", 32'(busy), 32'd1);
        check("b2b done_low", 32'(done), 32'd0);
        step(); step(); step();
        check("b2b not_done_yet", 32'(done), 32'd0);
        step();
        check("b2b done", 32'(done), 32'd1);
        check("b2b sum", sum, 32'd7);
        $display("op b2b: 3+4 -> sum=0x%08h", sum);
        step();

        run_op("sub_5_7", 1'b1, 32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        run_op("sub_ovf", 1'b1, 32'h8000_0000, 32'd1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);

        // Abort mid-operation; cout/overflow are 1 from the previous op, so clearing is visible.
        start = 1'b1; sub = 1'b0; a = 32'hFFFF_FFFF; b = 32'h1; cin = 1'b0;
        step();
        start = 1'b0;
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort sum", sum, 32'd0);
        check("abort cout", 32'(cout), 32'd0);
        check("abort overflow", 32'(overflow), 32'd0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done) pulses++;
        end
        check("abort no_done", pulses, 0);
        $display("op abort: done pulses after reset=%0d", pulses);
        run_op("post_abort", 1'b0, 32'd1, 32'd2, 1'b0, 32'd3, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
